// File: rtl/am2928_bus_ctl_pkg.sv
// +------------------------------------------------------------------+
// | am2928_ctl_pkg : shared types and constants for am2928_bus_ctl   |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
`default_nettype none

package am2928_ctl_pkg;

  localparam int DEF_NPORT = 4;
  localparam int DEF_IDW   = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRIVE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Inactive levels: active-low strobes idle high, source select idles at D inputs
  localparam logic c_CTL_OFF_N = 1'b1;
  localparam logic c_CTL_OFF_S = 1'b0;

endpackage

`default_nettype wire

// File: rtl/am2928_bus_ctl_if.sv
// +------------------------------------------------------------------+
// | am2928_bus_ctl_if : requester handshake and am2928 control pins  |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
`default_nettype none

interface am2928_bus_ctl_if
  import am2928_ctl_pkg::*;
#(
  parameter int NPORT = DEF_NPORT,
  parameter int IDW   = DEF_IDW
);
  logic [NPORT-1:0]     req;
  logic [NPORT*IDW-1:0] dst;
  logic [NPORT-1:0]     src;
  logic [NPORT-1:0]     gnt;
  logic [NPORT-1:0]     done;
  logic                 err;
  logic                 busy;
  logic [IDW-1:0]       owner;
  logic [NPORT-1:0]     endr_;
  logic [NPORT-1:0]     s;
  logic [NPORT-1:0]     be_;
  logic [NPORT-1:0]     enrec_;
  logic [NPORT-1:0]     oe_;

  modport master (
    output req, dst, src,
    input  gnt, done, err, busy, owner, endr_, s, be_, enrec_, oe_
  );

  modport slave (
    input  req, dst, src,
    output gnt, done, err, busy, owner, endr_, s, be_, enrec_, oe_
  );
endinterface

`default_nettype wire

// File: rtl/am2928_bus_ctl_arb.sv
// +------------------------------------------------------------------+
// | am2928_rr_arb : combinational round-robin picker, search from    |
// |                 ptr+1 wrapping modulo NPORT                      |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
`default_nettype none

module am2928_rr_arb #(
  parameter int NPORT = 4,
  parameter int IDW   = 2
) (
  input  wire logic [NPORT-1:0] i_req,
  input  wire logic [IDW-1:0]   i_ptr,
  output logic                  o_any,
  output logic [IDW-1:0]        o_winner
);

  int w_idx;

  // Scan farthest-first so the nearest requester after ptr is written last
  always_comb begin
    o_any    = 1'b0;
    o_winner = '0;
    w_idx    = 0;
    for (int k = NPORT; k >= 1; k--) begin
      w_idx = (int'(i_ptr) + k) % NPORT;
      if (i_req[w_idx[IDW-1:0]]) begin
        o_any    = 1'b1;
        o_winner = IDW'(w_idx);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/am2928_bus_ctl.sv
// +------------------------------------------------------------------+
// | am2928_bus_ctl : round-robin sequencer driving am2928 slice      |
// |   controls (load driver, drive+capture, present on Y).           |
// |   Option macro BACK2BACK_EN: re-arbitrate in DONE.               |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
`default_nettype none

module am2928_bus_ctl
  import am2928_ctl_pkg::*;
#(
  parameter int NPORT = DEF_NPORT,
  parameter int IDW   = DEF_IDW
) (
  input  wire logic        cp,
  input  wire logic        clr_,
  am2928_bus_ctl_if.slave  bus
);

  state_t           r_state;
  state_t           w_next_state;
  logic [IDW-1:0]   r_w;
  logic [IDW-1:0]   r_d;
  logic             r_sv;
  logic [IDW-1:0]   r_ptr;
  logic             w_ld;
  logic             w_any;
  logic [IDW-1:0]   w_win;
  logic [IDW-1:0]   w_arb_ptr;
  logic             w_dvalid;
  logic [IDW-1:0]   w_dst_arr [NPORT];

  logic [NPORT-1:0] w_gnt, w_done, w_endr_n, w_s, w_be_n, w_enrec_n, w_oe_n;
  logic             w_err;

  for (genvar g = 0; g < NPORT; g++) begin : g_dst
    assign w_dst_arr[g] = bus.dst[g*IDW +: IDW];
  end

`ifdef BACK2BACK_EN
  // In DONE the pointer update is still pending, so feed the winner directly
  assign w_arb_ptr = (r_state == ST_DONE) ? r_w : r_ptr;
`else
  assign w_arb_ptr = r_ptr;
`endif

  am2928_rr_arb #(.NPORT(NPORT), .IDW(IDW)) u_arb (
    .i_req    (bus.req),
    .i_ptr    (w_arb_ptr),
    .o_any    (w_any),
    .o_winner (w_win)
  );

  always_ff @(posedge cp or negedge clr_) begin
    if (!clr_) begin
      r_state <= ST_IDLE;
      r_w     <= '0;
      r_d     <= '0;
      r_sv    <= 1'b0;
      r_ptr   <= IDW'(NPORT-1);
    end else begin
      r_state <= w_next_state;
      if (w_ld) begin
        r_w  <= w_win;
        r_d  <= w_dst_arr[w_win];
        r_sv <= bus.src[w_win];
      end
      if (r_state == ST_DONE) begin
        r_ptr <= r_w;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_ld         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_next_state = ST_LOAD;
          w_ld         = 1'b1;
        end
      end
      ST_LOAD:  w_next_state = ST_DRIVE;
      ST_DRIVE: w_next_state = ST_DONE;
      ST_DONE: begin
        w_next_state = ST_IDLE;
`ifdef BACK2BACK_EN
        if (w_any) begin
          w_next_state = ST_LOAD;
          w_ld         = 1'b1;
        end
`endif
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  assign w_dvalid = (int'(r_d) < NPORT);

  always_comb begin
    w_gnt     = '0;
    w_done    = '0;
    w_err     = 1'b0;
    w_endr_n  = {NPORT{c_CTL_OFF_N}};
    w_s       = {NPORT{c_CTL_OFF_S}};
    w_be_n    = {NPORT{c_CTL_OFF_N}};
    w_enrec_n = {NPORT{c_CTL_OFF_N}};
    w_oe_n    = {NPORT{c_CTL_OFF_N}};
    case (r_state)
      ST_LOAD: begin
        w_gnt[r_w]    = 1'b1;
        w_endr_n[r_w] = 1'b0;
        w_s[r_w]      = r_sv;
      end
      ST_DRIVE: begin
        w_gnt[r_w]  = 1'b1;
        w_be_n[r_w] = 1'b0;
        if (w_dvalid) w_enrec_n[r_d] = 1'b0;
      end
      ST_DONE: begin
        w_gnt[r_w]  = 1'b1;
        w_done[r_w] = 1'b1;
        w_err       = !w_dvalid;
        if (w_dvalid) w_oe_n[r_d] = 1'b0;
      end
      default: ;
    endcase
  end

  assign bus.gnt    = w_gnt;
  assign bus.done   = w_done;
  assign bus.err    = w_err;
  assign bus.busy   = (r_state != ST_IDLE);
  assign bus.owner  = r_w;
  assign bus.endr_  = w_endr_n;
  assign bus.s      = w_s;
  assign bus.be_    = w_be_n;
  assign bus.enrec_ = w_enrec_n;
  assign bus.oe_    = w_oe_n;

endmodule

`default_nettype wire

// File: tb/tb_am2928_bus_ctl.sv
// +------------------------------------------------------------------+
// | tb_am2928_bus_ctl : self-checking bench, transaction-level model |
// | Rev 1.0 - initial release                                        |
// +------------------------------------------------------------------+
`default_nettype none

module tb_am2928_bus_ctl;

  logic cp;
  logic clr_;
  int   checks;
  int   failures;

  am2928_bus_ctl_if #(.NPORT(4), .IDW(2)) bus4 ();
  am2928_bus_ctl_if #(.NPORT(3), .IDW(2)) bus3 ();

  am2928_bus_ctl #(.NPORT(4), .IDW(2)) u_dut4 (.cp(cp), .clr_(clr_), .bus(bus4.slave));
  am2928_bus_ctl #(.NPORT(3), .IDW(2)) u_dut3 (.cp(cp), .clr_(clr_), .bus(bus3.slave));

  initial cp = 1'b0;
  always #5 cp = ~cp;

  logic [31:0] obs4;
  assign obs4 = {bus4.gnt, bus4.done, bus4.err, bus4.busy, bus4.owner,
                 bus4.endr_, bus4.s, bus4.be_, bus4.enrec_, bus4.oe_};

  localparam logic [31:0] RST_VEC = {12'h000, 4'hF, 4'h0, 4'hF, 4'hF, 4'hF};

`ifdef BACK2BACK_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  // Transaction model: one in-flight transfer with its age in cycles (0..2)
  bit m_active;
  int m_age, m_w, m_d, m_ptr;
  bit m_sv;

  function automatic void model_reset();
    m_active = 0; m_age = 0; m_w = 0; m_d = 0; m_sv = 0; m_ptr = 3;
  endfunction

  function automatic void model_edge();
    bit         may_start;
    bit         found;
    logic [3:0] rq;
    logic [7:0] dv;
    logic [3:0] sv;
    rq = bus4.req; dv = bus4.dst; sv = bus4.src;
    may_start = 0; found = 0;
    if (m_active) begin
      if (m_age == 2) begin
        m_active  = 0;
        m_ptr     = m_w;
        may_start = B2B;
      end else begin
        m_age = m_age + 1;
      end
    end else begin
      may_start = 1;
    end
    if (may_start) begin
      for (int k = 1; k <= 4; k++) begin
        int i;
        i = (m_ptr + k) % 4;
        if (!found && rq[i]) begin
          found = 1; m_active = 1; m_age = 0; m_w = i;
          m_d = int'((dv >> (2*i)) & 8'h3);
          m_sv = sv[i];
        end
      end
    end
  endfunction

  function automatic logic [31:0] model_vec();
    logic [3:0] g, dn, en, s, be, er, oe;
    logic       err;
    g = '0; dn = '0; s = '0; en = 4'hF; be = 4'hF; er = 4'hF; oe = 4'hF; err = 0;
    if (m_active) begin
      g[m_w] = 1'b1;
      case (m_age)
        0: begin en[m_w] = 1'b0; s[m_w] = m_sv; end
        1: begin be[m_w] = 1'b0; if (m_d < 4) er[m_d] = 1'b0; end
        default: begin
          dn[m_w] = 1'b1; err = (m_d >= 4);
          if (m_d < 4) oe[m_d] = 1'b0;
        end
      endcase
    end
    return {g, dn, err, m_active, 2'(m_w), en, s, be, er, oe};
  endfunction

  task automatic cyc();
    @(posedge cp);
    model_edge();
    @(negedge cp);
  endtask

  task automatic do_reset();
    clr_ = 1'b0;
    model_reset();
    @(posedge cp);
    @(negedge cp);
    clr_ = 1'b1;
  endtask

  task automatic idle_inputs();
    bus4.req = '0; bus4.dst = '0; bus4.src = '0;
    bus3.req = '0; bus3.dst = '0; bus3.src = '0;
  endtask

  task automatic test_reset();
    clr_ = 1'b0;
    idle_inputs();
    model_reset();
    #1;
    checks++;
    if (obs4 !== RST_VEC) begin
      failures++; $display("FAIL reset_state obs=%h exp=%h", obs4, RST_VEC);
    end
    checks++;
    if ({bus3.gnt, bus3.busy, bus3.endr_, bus3.be_, bus3.enrec_, bus3.oe_, bus3.s} !== {3'b000, 1'b0, 12'hFFF, 3'b000}) begin
      failures++; $display("FAIL reset_state3 gnt=%b be_=%b oe_=%b", bus3.gnt, bus3.be_, bus3.oe_);
    end
    @(negedge cp);
    clr_ = 1'b1;
    bus4.req = 4'b0001;
    cyc();
    cyc();
    checks++;
    if (bus4.be_ !== 4'b1110) begin
      failures++; $display("FAIL reset_pre_drive be_=%b exp=1110", bus4.be_);
    end
    #2 clr_ = 1'b0;
    #1;
    model_reset();
    checks++;
    if (obs4 !== RST_VEC) begin
      failures++; $display("FAIL reset_mid_drive obs=%h exp=%h", obs4, RST_VEC);
    end
    @(posedge cp);
    @(negedge cp);
    clr_ = 1'b1;
    cyc();
    checks++;
    if (bus4.gnt !== 4'b0001) begin
      failures++; $display("FAIL reset_first_grant gnt=%b exp=0001", bus4.gnt);
    end
    bus4.req = '0;
    repeat (4) cyc();
  endtask

  task automatic test_single();
    do_reset();
    bus4.req = 4'b0010; bus4.dst = 8'b00_00_11_00; bus4.src = 4'b0000;
    cyc();
    bus4.req = '0;
    checks++;
    if ({bus4.gnt, bus4.endr_, bus4.s, bus4.be_} !== {4'b0010, 4'b1101, 4'b0000, 4'b1111}) begin
      failures++; $display("FAIL single_load gnt=%b endr_=%b s=%b be_=%b", bus4.gnt, bus4.endr_, bus4.s, bus4.be_);
    end
    cyc();
    checks++;
    if ({bus4.be_, bus4.enrec_, bus4.endr_} !== {4'b1101, 4'b0111, 4'b1111}) begin
      failures++; $display("FAIL single_drive be_=%b enrec_=%b endr_=%b", bus4.be_, bus4.enrec_, bus4.endr_);
    end
    cyc();
    checks++;
    if ({bus4.oe_, bus4.done, bus4.err, bus4.owner} !== {4'b0111, 4'b0010, 1'b0, 2'd1}) begin
      failures++; $display("FAIL single_done oe_=%b done=%b err=%b owner=%0d", bus4.oe_, bus4.done, bus4.err, bus4.owner);
    end
    cyc();
    checks++;
    if ({bus4.gnt, bus4.busy, bus4.done} !== {4'b0000, 1'b0, 4'b0000}) begin
      failures++; $display("FAIL single_idle gnt=%b busy=%b done=%b", bus4.gnt, bus4.busy, bus4.done);
    end
  endtask

  task automatic test_round_robin();
    int q[$];
    int exp_order[5] = '{0, 1, 2, 3, 0};
    do_reset();
    bus4.req = 4'b1111; bus4.dst = 8'($urandom); bus4.src = 4'($urandom);
    for (int c = 0; c < 22; c++) begin
      cyc();
      checks++;
      if (obs4 !== model_vec()) begin
        failures++; $display("FAIL rr_cycle%0d obs=%h exp=%h", c, obs4, model_vec());
      end
      for (int i = 0; i < 4; i++) if (bus4.done[i]) q.push_back(i);
    end
    bus4.req = '0;
    repeat (4) cyc();
    checks++;
    if (q.size() < 5) begin
      failures++; $display("FAIL rr_count dones=%0d exp>=5", q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        checks++;
        if (q[i] !== exp_order[i]) begin
          failures++; $display("FAIL rr_order idx%0d got=%0d exp=%0d", i, q[i], exp_order[i]);
        end
      end
    end
  endtask

  task automatic test_loopback();
    do_reset();
    bus4.req = 4'b0001; bus4.dst = 8'h00; bus4.src = 4'b0001;
    cyc();
    bus4.req = '0;
    checks++;
    if ({bus4.s, bus4.endr_} !== {4'b0001, 4'b1110}) begin
      failures++; $display("FAIL loop_load s=%b endr_=%b", bus4.s, bus4.endr_);
    end
    cyc();
    checks++;
    if ({bus4.be_, bus4.enrec_} !== {4'b1110, 4'b1110}) begin
      failures++; $display("FAIL loop_drive be_=%b enrec_=%b", bus4.be_, bus4.enrec_);
    end
    cyc();
    checks++;
    if ({bus4.done, bus4.oe_} !== {4'b0001, 4'b1110}) begin
      failures++; $display("FAIL loop_done done=%b oe_=%b", bus4.done, bus4.oe_);
    end
    cyc();
  endtask

  task automatic test_bad_dst();
    do_reset();
    bus3.req = 3'b100; bus3.dst = 6'b11_00_00; bus3.src = 3'b000;
    cyc();
    checks++;
    if ({bus3.endr_, bus3.enrec_, bus3.oe_, bus3.err} !== {3'b011, 3'b111, 3'b111, 1'b0}) begin
      failures++; $display("FAIL bad_load endr_=%b enrec_=%b oe_=%b err=%b", bus3.endr_, bus3.enrec_, bus3.oe_, bus3.err);
    end
    bus3.req = '0;
    cyc();
    checks++;
    if ({bus3.be_, bus3.enrec_, bus3.oe_} !== {3'b011, 3'b111, 3'b111}) begin
      failures++; $display("FAIL bad_drive be_=%b enrec_=%b oe_=%b", bus3.be_, bus3.enrec_, bus3.oe_);
    end
    cyc();
    checks++;
    if ({bus3.done, bus3.err, bus3.oe_, bus3.enrec_} !== {3'b100, 1'b1, 3'b111, 3'b111}) begin
      failures++; $display("FAIL bad_done done=%b err=%b oe_=%b", bus3.done, bus3.err, bus3.oe_);
    end
    cyc();
    checks++;
    if ({bus3.done, bus3.err, bus3.busy} !== {3'b000, 1'b0, 1'b0}) begin
      failures++; $display("FAIL bad_after done=%b err=%b busy=%b", bus3.done, bus3.err, bus3.busy);
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    int first;
    int second;
    first = -1; second = -1;
    do_reset();
    bus4.req = 4'b0011; bus4.dst = 8'($urandom); bus4.src = 4'($urandom);
    for (int c = 1; c <= 12; c++) begin
      cyc();
      checks++;
      if (obs4 !== model_vec()) begin
        failures++; $display("FAIL b2b_cycle%0d obs=%h exp=%h", c, obs4, model_vec());
      end
      if (first > 0 && c == first + 1) begin
        checks++;
        if (bus4.gnt !== (B2B ? 4'b0010 : 4'b0000)) begin
          failures++; $display("FAIL b2b_gnt_after_done gnt=%b exp=%b", bus4.gnt, (B2B ? 4'b0010 : 4'b0000));
        end
      end
      if (bus4.done != 0) begin
        if (first < 0) first = c;
        else if (second < 0) second = c;
      end
    end
    bus4.req = '0;
    repeat (4) cyc();
    checks++;
    if (first != 3 || (second - first) != (B2B ? 3 : 4)) begin
      failures++; $display("FAIL b2b_spacing first=%0d gap=%0d exp first=3 gap=%0d", first, second - first, (B2B ? 3 : 4));
    end
  endtask

  task automatic test_random();
    int nlow;
    do_reset();
    for (int c = 0; c < 300; c++) begin
      bus4.req = 4'($urandom_range(0, 15));
      bus4.dst = 8'($urandom);
      bus4.src = 4'($urandom);
      cyc();
      checks++;
      if (obs4 !== model_vec()) begin
        failures++; $display("FAIL rand_cycle%0d obs=%h exp=%h", c, obs4, model_vec());
      end
      nlow = 0;
      for (int i = 0; i < 4; i++) nlow += (bus4.be_[i] === 1'b0) ? 1 : 0;
      checks++;
      if (nlow > 1) begin
        failures++; $display("FAIL rand_be_onehot cycle%0d be_=%b", c, bus4.be_);
      end
    end
    bus4.req = '0;
    repeat (4) cyc();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_single();
    test_round_robin();
    test_loopback();
    test_bad_dst();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
